// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises raw interrupt lines and latches their rising edges as pending.
//   It picks the lowest-index masked-in pending source and runs a req/ack/done handshake with the CPU.
//   Latency: a pending bit appears 3 edges after irq_in is sampled high; irq_req follows 1 edge later.
//   Backpressure: the request holds until irq_ack arrives. While the request or the ISR is open,
//   new edges only accumulate in pending.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   irq_in[N_IRQ]           raw asynchronous level sources (bit0 = timer)
//   mask_we, mask_in        mask register write strobe and data (1 = enabled)
//   irq_ack, irq_done       CPU handshake pulses
//   irq_req, irq_id,        request, latched source id, vector address
//   irq_vector
//   pending, busy           pending status, 1 while the ISR is being serviced
module interrupt_controller #(
  parameter int N_IRQ      = 3,
  parameter int ID_W       = 2,
  parameter int ADDR_W     = 10,
  parameter int VEC_BASE   = 1,
  parameter int VEC_STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_in,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic [ADDR_W-1:0] irq_vector,
  output logic [N_IRQ-1:0]  pending,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LP_BASE   = ADDR_W'(VEC_BASE);
  localparam logic [ADDR_W-1:0] LP_STRIDE = ADDR_W'(VEC_STRIDE);

  logic [N_IRQ-1:0] r_sync1, r_sync2, r_prev;
  logic [N_IRQ-1:0] r_pending, r_mask;
  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_eligible;
  logic [N_IRQ-1:0] w_clr;
  logic [ID_W-1:0]  w_winner;

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_eligible = r_pending & r_mask;

  // Clear only the latched id, and only when the ack lands in REQ.
  always_comb begin
    w_clr = '0;
    if (r_state == ST_REQ && irq_ack) begin
      w_clr = N_IRQ'(1) << r_id;
    end
  end

  // Set is OR-ed in after the clear, so a new edge wins over the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_in;
      end
    end
  end

  // Scan from the top so the lowest eligible index is the last to assign.
  always_comb begin
    w_winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_id_nxt    = w_winner;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_state_nxt = ST_SERV;
        end
      end
      ST_SERV: begin
        if (irq_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign irq_req    = (r_state == ST_REQ);
  assign busy       = (r_state == ST_SERV);
  assign irq_id     = r_id;
  assign irq_vector = LP_BASE + ADDR_W'(r_id) * LP_STRIDE;
  assign pending    = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [2:0] mask_in = '0;
  logic       irq_ack = 1'b0;
  logic       irq_done = 1'b0;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [9:0] irq_vector;
  logic [2:0] pending;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs changed after this take effect next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [2:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  // Hold irq_in at v for three edges, then drop it.
  task automatic pulse(input logic [2:0] v);
    irq_in = v;
    tick();
    tick();
    tick();
    irq_in = '0;
  endtask

  // Expects an open request for id; acks, checks pending, then completes the ISR.
  task automatic serve(input string tag, input logic [1:0] id, input logic [2:0] pend_after_ack);
    chk({tag, "_req"}, 32'(irq_req), 32'd1);
    chk({tag, "_id"}, 32'(irq_id), 32'(id));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk({tag, "_pend_ack"}, 32'(pending), 32'(pend_after_ack));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_req_serv"}, 32'(irq_req), 32'd0);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_vec", 32'(irq_vector), 32'd1);
    reset = 1'b0;
    tick();

    // 1: single source, latency and vector
    write_mask(3'b111);
    irq_in = 3'b010;
    tick();
    tick();
    chk("t1_pend_e2", 32'(pending), 32'd0);
    tick();
    irq_in = '0;
    chk("t1_pend_e3", 32'(pending), 32'b010);
    chk("t1_req_e3", 32'(irq_req), 32'd0);
    tick();
    chk("t1_vec", 32'(irq_vector), 32'd2);
    serve("t1", 2'd1, 3'b000);
    tick();
    chk("t1_noreq", 32'(irq_req), 32'd0);

    // 2: simultaneous edges, priority order
    pulse(3'b111);
    chk("t2_pend", 32'(pending), 32'b111);
    tick();
    chk("t2_vec0", 32'(irq_vector), 32'd1);
    serve("t2a", 2'd0, 3'b110);
    tick();
    chk("t2_vec1", 32'(irq_vector), 32'd2);
    serve("t2b", 2'd1, 3'b100);
    tick();
    chk("t2_vec2", 32'(irq_vector), 32'd3);
    serve("t2c", 2'd2, 3'b000);

    // 3: masked source pends without requesting; ack in IDLE is ignored
    write_mask(3'b001);
    pulse(3'b100);
    tick();
    chk("t3_pend", 32'(pending), 32'b100);
    chk("t3_noreq", 32'(irq_req), 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t3_ack_idle_pend", 32'(pending), 32'b100);
    chk("t3_ack_idle_busy", 32'(busy), 32'd0);
    write_mask(3'b100);
    chk("t3_req_wr", 32'(irq_req), 32'd0);
    tick();
    serve("t3", 2'd2, 3'b000);

    // 4: masking in REQ does not withdraw; ack clears only the latched id
    write_mask(3'b111);
    pulse(3'b110);
    tick();
    chk("t4_req_id", 32'(irq_id), 32'd1);
    write_mask(3'b000);
    serve("t4", 2'd1, 3'b100);
    tick();
    chk("t4_masked_noreq", 32'(irq_req), 32'd0);
    write_mask(3'b111);
    tick();
    serve("t4b", 2'd2, 3'b000);

    // 5: new edge coincident with ack wins; done in REQ ignored
    pulse(3'b010);
    tick();
    chk("t5_req", 32'(irq_req), 32'd1);
    irq_in = 3'b010;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("t5_done_in_req", 32'(irq_req), 32'd1);
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_in = '0;
    chk("t5_pend_kept", 32'(pending), 32'b010);
    chk("t5_busy", 32'(busy), 32'd1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    tick();
    serve("t5b", 2'd1, 3'b000);

    // 6: reset in SERV, then held-high input with reset-cleared mask
    pulse(3'b101);
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t6_serv", 32'(busy), 32'd1);
    chk("t6_pend_pre", 32'(pending), 32'b100);
    irq_in = 3'b001;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_req", 32'(irq_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    chk("t6_rst_vec", 32'(irq_vector), 32'd1);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_held_noreq", 32'(irq_req), 32'd0);
    chk("t6_held_busy", 32'(busy), 32'd0);
    irq_in = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
